div4b_seq: RTL and testbench
============================

DIV4B_SEQ -- requirements
Module: div4b_seq

Interface
REQ-001 SHALL: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL: rst_n  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
REQ-003 SHALL: start  input  1  request pulse; sampled on rising edge of clk.
REQ-004 SHALL: A  input  4  unsigned dividend; sampled only on the accepting edge.
REQ-005 SHALL: B  input  4  unsigned divisor; sampled only on the accepting edge.
REQ-006 SHALL: busy  output  1  high while a division is in progress.
REQ-007 SHALL: done  output  1  single-cycle completion pulse.
REQ-008 SHALL: Q  output  4  registered quotient; holds until the next completion.
REQ-009 SHALL: R  output  4  registered remainder; holds until the next completion.
REQ-010 SHALL: div0  output  1  registered divide-by-zero flag for the last completed operation.

Function
REQ-011 SHALL: implement restoring shift-subtract division, one quotient bit per clk cycle, MSB first, using a 5-bit partial remainder and a 4-bit subtract with borrow out.
REQ-012 SHALL: have FSM states IDLE and CALC.
  - IDLE -> CALC: start=1 and B!=0.
  - CALC -> IDLE: after the 4th iteration edge.
REQ-013 SHALL: on the accepting edge (IDLE, start=1, B!=0), capture A and B, clear the partial remainder, clear the 2-bit iteration counter, set busy=1, and enter CALC.
REQ-014 SHALL: perform each CALC iteration as follows.
  - Shift {rem, dividend MSB} left by one.
  - Trial subtract B.
  - On no borrow: keep the difference and set quotient bit=1.
  - On borrow: restore the previous value and set quotient bit=0.
  - Increment the counter.
REQ-015 SHALL: on the edge completing iteration 4, load Q and R, set done=1 for exactly one cycle, clear busy and div0, and return to IDLE; latency is exactly 4 cycles from the accepting edge to done high.
REQ-016 SHALL: on start=1 in IDLE with B==0, skip CALC and, on that same edge, load Q=4'hF and R=A, and assert div0=1 and done=1 for one cycle; busy stays 0.
REQ-017 SHALL: ignore start while busy=1; the in-flight operation and its operands are unaffected.
REQ-018 SHALL: ignore changes to A and B after the accepting edge.
REQ-019 SHALL: accept start in the cycle in which done=1 (FSM already in IDLE), so back-to-back operations have one cycle per result plus four cycles of compute.
REQ-020 SHALL: keep Q, R and div0 stable between completions; done SHALL never be high while busy=1.
REQ-021 SHALL: guarantee R < B and Q*B + R == A for every B != 0 over the full 0..15 operand range.

Reset
REQ-022 SHALL: on rst_n=0, asynchronously force state=IDLE, busy=0, done=0, Q=4'h0, R=4'h0, div0=0, and clear the counter and internal registers.
REQ-023 SHALL: on reset during CALC, abort the operation with no done pulse, so the partial result is never visible.
REQ-024 SHALL: on deassertion of rst_n, accept start from the first following rising edge.

Verification
REQ-025 SHALL: A=13, B=3, start one cycle -> busy high for 4 cycles; done on the 4th edge with Q=4, R=1, div0=0.
REQ-026 SHALL: exhaustive sweep A=0..15, B=1..15 -> Q=A/B and R=A%B for every pair; each done occurs exactly 4 cycles after its start.
REQ-027 SHALL: A=9, B=0 -> done on the accepting edge with Q=4'hF, R=9, div0=1, busy never high; a following A=6, B=2 -> Q=3, R=0, div0 cleared.
REQ-028 SHALL: A=15, B=1 started, then A=2, B=7 with start=1 two cycles later -> second start ignored; result Q=15, R=0; then start A=2, B=7 in the done cycle -> Q=0, R=2 four cycles later.
REQ-029 SHALL: A=14, B=5 started, rst_n pulsed low after 2 cycles -> all outputs 0 immediately, no done pulse; a restart after release -> Q=2, R=4.

Source files
------------

// File: rtl/div4b_seq.sv
// Sequential 4-bit unsigned restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero finishes on the accepting edge with Q=4'hF, R=A and div0 set.
module div4b_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       busy,
    output logic       done,
    output logic [3:0] Q,
    output logic [3:0] R,
    output logic       div0,
    output logic       dbg_state_o
);

    typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [3:0] dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
    logic [3:0] b_q, b_d;
    logic [4:0] rem_q, rem_d;
    logic [1:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] q_q, q_d;
    logic [3:0] r_q, r_d;
    logic       div0_q, div0_d;

    logic [4:0] shifted;
    logic [5:0] sub;
    logic       borrow;
    logic [4:0] rem_next;
    logic       qbit;

    // Partial remainder stays below B, so its top bit is never needed in the shift.
    assign shifted  = {rem_q[3:0], dvd_q[3]};
    assign sub      = {1'b0, shifted} - {2'b00, b_q};
    assign borrow   = sub[5];
    assign rem_next = borrow ? shifted : sub[4:0];
    assign qbit     = ~borrow;

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        b_d     = b_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        q_d     = q_q;
        r_d     = r_q;
        div0_d  = div0_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (B != 4'd0) begin
                        state_d = CALC;
                        dvd_d   = A;
                        b_d     = B;
                        rem_d   = 5'd0;
                        cnt_d   = 2'd0;
                        busy_d  = 1'b1;
                    end else begin
                        q_d    = 4'hF;
                        r_d    = A;
                        div0_d = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            CALC: begin
                rem_d = rem_next;
                dvd_d = {dvd_q[2:0], qbit};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    q_d     = {dvd_q[2:0], qbit};
                    r_d     = rem_next[3:0];
                    div0_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= 4'd0;
            b_q     <= 4'd0;
            rem_q   <= 5'd0;
            cnt_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= 4'd0;
            r_q     <= 4'd0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_q     <= q_d;
            r_q     <= r_d;
            div0_q  <= div0_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign Q           = q_q;
    assign R           = r_q;
    assign div0        = div0_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div4b_seq.sv
// Directed bench for div4b_seq: reset, worked example, full sweep, divide-by-zero,
// ignored start while busy, back-to-back start in the done cycle, reset abort.
module tb_div4b_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] A = 4'd0;
    logic [3:0] B = 4'd0;
    logic       busy, done, div0, dbg_state;
    logic [3:0] Q, R;

    int checks = 0;
    int failures = 0;

    div4b_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .Q(Q), .R(R), .div0(div0),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Drive one start pulse; returns #1 after the edge that samples it.
    task automatic pulse_start(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count edges until done is seen (#1 after each edge); -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, done, Q, R, div0, dbg_state} !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b Q=%0d R=%0d div0=%b st=%b exp all 0",
                     busy, done, Q, R, div0, dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        pulse_start(4'd13, 4'd3);
        A = 4'd2; B = 4'd0;  // must not disturb the running operation
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || dbg_state !== 1'b1) begin
                failures++;
                $display("FAIL basic_busy cycle=%0d got busy=%b done=%b st=%b exp 1 0 1",
                         i, busy, done, dbg_state);
            end
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        wait_done(lat);
        checks++;
        if (lat !== 1 || busy !== 1'b0 || Q !== 4'd4 || R !== 4'd1 || div0 !== 1'b0) begin
            failures++;
            $display("FAIL basic_result got lat=%0d busy=%b Q=%0d R=%0d div0=%b exp lat=1 busy=0 Q=4 R=1 div0=0",
                     lat, busy, Q, R, div0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || Q !== 4'd4 || R !== 4'd1) begin
            failures++;
            $display("FAIL basic_hold got done=%b Q=%0d R=%0d exp 0 4 1", done, Q, R);
        end
    endtask

    task automatic test_sweep();
        int lat;
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                pulse_start(4'(a), 4'(b));
                wait_done(lat);
                checks++;
                if (lat !== 4) begin
                    failures++;
                    $display("FAIL sweep_latency a=%0d b=%0d got %0d exp 4", a, b, lat);
                end
                checks++;
                if (Q !== 4'(a / b) || R !== 4'(a % b)) begin
                    failures++;
                    $display("FAIL sweep_result a=%0d b=%0d got Q=%0d R=%0d exp Q=%0d R=%0d",
                             a, b, Q, R, a / b, a % b);
                end
            end
        end
    endtask

    task automatic test_div0();
        int lat;
        pulse_start(4'd9, 4'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || Q !== 4'hF || R !== 4'd9 || div0 !== 1'b1) begin
            failures++;
            $display("FAIL div0_result got done=%b busy=%b Q=%0d R=%0d div0=%b exp 1 0 15 9 1",
                     done, busy, Q, R, div0);
        end
        pulse_start(4'd6, 4'd2);
        checks++;
        if (div0 !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL div0_hold got div0=%b done=%b busy=%b exp 1 0 1", div0, done, busy);
        end
        wait_done(lat);
        checks++;
        if (lat !== 4 || Q !== 4'd3 || R !== 4'd0 || div0 !== 1'b0) begin
            failures++;
            $display("FAIL div0_recover got lat=%0d Q=%0d R=%0d div0=%b exp 4 3 0 0", lat, Q, R, div0);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        pulse_start(4'd15, 4'd1);
        @(posedge clk);
        pulse_start(4'd2, 4'd7);  // lands two edges into the running operation
        wait_done(lat);
        checks++;
        if (lat !== 2 || Q !== 4'd15 || R !== 4'd0) begin
            failures++;
            $display("FAIL ignore_start got lat=%0d Q=%0d R=%0d exp 2 15 0", lat, Q, R);
        end
        A = 4'd2; B = 4'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept got busy=%b done=%b exp 1 0", busy, done);
        end
        wait_done(lat);
        checks++;
        if (lat !== 4 || Q !== 4'd0 || R !== 4'd2) begin
            failures++;
            $display("FAIL b2b_result got lat=%0d Q=%0d R=%0d exp 4 0 2", lat, Q, R);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen_done;
        pulse_start(4'd14, 4'd5);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, Q, R, div0, dbg_state} !== 12'd0) begin
            failures++;
            $display("FAIL abort_outputs got busy=%b done=%b Q=%0d R=%0d div0=%b st=%b exp all 0",
                     busy, done, Q, R, div0, dbg_state);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        checks++;
        if (seen_done !== 0 || Q !== 4'd0 || R !== 4'd0) begin
            failures++;
            $display("FAIL abort_no_done got done_pulses=%0d Q=%0d R=%0d exp 0 0 0", seen_done, Q, R);
        end
        pulse_start(4'd14, 4'd5);
        wait_done(lat);
        checks++;
        if (lat !== 4 || Q !== 4'd2 || R !== 4'd4 || div0 !== 1'b0) begin
            failures++;
            $display("FAIL abort_restart got lat=%0d Q=%0d R=%0d div0=%b exp 4 2 4 0", lat, Q, R, div0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_div0();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
